alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator side of the 32-bit ALU interface: accepts register-level commands over a valid/ready handshake and owns a small register file.
- For each command it drives a, b and opCode into the combinational ALU, captures result and zero/carry/overflow, writes the result back and pulses done.
- Sits between the host/test controller and alu_32_bit; it is the only block driving ALU operands.

Parameters:
WIDTH, 32, datapath width; must match the ALU.
NREGS, 8, register file depth.
AW, 3, register address width (log2 NREGS).

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  asynchronous, active-low; 0 = reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command (high only in IDLE).
cmd_op  in  4  ALU opcode.
cmd_ra  in  AW  source register A.
cmd_rb  in  AW  source register B.
cmd_rd  in  AW  destination register.
ld_en  in  1  host register load strobe.
ld_addr  in  AW  load address.
ld_data  in  WIDTH  load data.
rd_addr  in  AW  readback address.
rd_data  out  WIDTH  combinational readback, rf[rd_addr].
alu_a  out  WIDTH  operand to ALU a.
alu_b  out  WIDTH  operand to ALU b.
alu_op  out  4  opcode to ALU.
alu_result  in  WIDTH  ALU result.
alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags.
done  out  1  one-cycle completion pulse.
done_data  out  WIDTH  value written by the completed command.
flags  out  3  {zero,carry,overflow} of the last completed ALU command.
err  out  1  last completed command had an illegal opcode.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all rf entries 0; alu_a=alu_b=0; alu_op=0000 (NOOP); done=0; done_data=0; flags=000; err=0; cmd_ready=1 once reset is released.
- FSM: IDLE -> EXEC -> WB -> IDLE. No other transitions.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge N:
    - alu_a<=rf[cmd_ra]; alu_b<=rf[cmd_rb]; alu_op<=cmd_op; rd and op latched; go EXEC.
  - EXEC (cycle N+1): operands stable. At edge N+2:
    - Capture alu_result and flags per the opcode rules below.
    - alu_op<=0000; alu_a and alu_b hold their values; go WB.
  - WB (cycle N+2..N+3): done=1 for exactly one cycle. done_data, flags and err are valid and hold until the next completion. Go IDLE.
  - Throughput: one command per 3 cycles. cmd_ready=0 in EXEC and WB.
- Opcode rules:
  - 0011 OR, 0101 AND, 0110 ADD, 1000 SUB: rf[rd]<=alu_result; flags<=ALU flags; err<=0.
  - 1100, 1101, 1110 (compare ops): rf[rd]<=alu_result; the ALU produces a 1-bit result in bit 0, with bits 31:1 from the ALU as-is. flags<=ALU flags; err<=0.
  - 0000 NOOP: no rf write; done_data<=rf[rd]; flags unchanged; err<=0.
  - 0001 RESET: rf[rd]<=0 without using the ALU result; done_data=0; flags<=100; err<=0.
  - 1111 ERROR or any undefined opcode: no rf write; done_data=0; flags unchanged; err<=1.
- Host load:
  - ld_en is honoured only in IDLE and is ignored elsewhere.
  - ld_en and a command accepted in the same IDLE cycle: the load writes at edge N. Operand capture at edge N uses the pre-load value.
  - ld_addr==cmd_rd in that case: the later WB write wins.
- Source registers: ra==rb and rd==ra are legal. Operands are sampled at acceptance, so a write to rd never affects the current command.
- rd_data is combinational from rf and reflects a write in the cycle after the write edge.
- Reset asserted mid-command: the command is aborted immediately, with no writeback and no done pulse; all reset values apply.
- cmd_* inputs are ignored when cmd_ready=0. A held cmd_valid is accepted on the next IDLE cycle.

Test Plan:
1. Load r1=0xFFFFFFFF, r2=0x00000001; ADD rd=r3 -> alu_a/alu_b/alu_op=6 during EXEC; done 3 cycles after accept; r3=0, flags zero=1, carry=1.
2. r1=5, r2=7; SUB rd=r4 -> r4=0xFFFFFFFE, zero=0; then LESS_THAN(14) r1,r2 rd=r5 -> r5=1.
3. Opcode 1111, then opcode 0010 -> err=1 both times, no rf change (readback unchanged), flags hold the previous value, done pulses.
4. cmd_valid held high with 4 queued ANDs -> accepts spaced exactly 3 cycles apart; cmd_ready low in EXEC/WB; ld_en during EXEC ignored.
5. Reset low during EXEC of ADD into r6 (r6 preloaded 0x1234) -> no done pulse; after release all rf=0, alu_op=0000, cmd_ready=1.
6. RESET opcode (0001) on r2=0xDEADBEEF -> r2=0, done_data=0, flags=100.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command issuer for the 32-bit combinational ALU. It owns a small register file, drives the
// ALU operands for one command at a time and writes the result back.
module alu_cmd_issuer #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [AW-1:0]    cmd_rd,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             done,
  output logic [WIDTH-1:0] done_data,
  output logic [2:0]       flags,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  localparam logic [1:0] CLS_ALU   = 2'd0;
  localparam logic [1:0] CLS_NOOP  = 2'd1;
  localparam logic [1:0] CLS_CLEAR = 2'd2;
  localparam logic [1:0] CLS_ILL   = 2'd3;

  // Sorts an opcode into how its completion is handled.
  function automatic logic [1:0] op_class(input logic [3:0] op);
    case (op)
      4'b0011, 4'b0101, 4'b0110, 4'b1000,
      4'b1100, 4'b1101, 4'b1110: op_class = CLS_ALU;
      4'b0000:                   op_class = CLS_NOOP;
      4'b0001:                   op_class = CLS_CLEAR;
      default:                   op_class = CLS_ILL;
    endcase
  endfunction

  logic [1:0]       state;
  logic [WIDTH-1:0] rf [NREGS];
  logic [AW-1:0]    rd_p0;
  logic [3:0]       op_p0;

  assign cmd_ready = (state == IDLE);
  assign rd_data   = rf[rd_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      rd_p0     <= '0;
      op_p0     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      done      <= 1'b0;
      done_data <= '0;
      flags     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        // IDLE: host loads and command acceptance; operands read the pre-load contents.
        IDLE: begin
          done <= 1'b0;
          if (ld_en) rf[ld_addr] <= ld_data;
          if (cmd_valid) begin
            alu_a  <= rf[cmd_ra];
            alu_b  <= rf[cmd_rb];
            alu_op <= cmd_op;
            rd_p0  <= cmd_rd;
            op_p0  <= cmd_op;
            state  <= EXEC;
          end
        end
        // EXEC -> WB: capture the ALU outputs and write back; a load in this same
        // IDLE-accept cycle has already landed, so this write wins on a shared address.
        EXEC: begin
          alu_op <= '0;
          done   <= 1'b1;
          state  <= WB;
          case (op_class(op_p0))
            CLS_ALU: begin
              rf[rd_p0] <= alu_result;
              done_data <= alu_result;
              flags     <= {alu_zero, alu_carry, alu_overflow};
              err       <= 1'b0;
            end
            CLS_NOOP: begin
              done_data <= rf[rd_p0];
              err       <= 1'b0;
            end
            CLS_CLEAR: begin
              rf[rd_p0] <= '0;
              done_data <= '0;
              flags     <= 3'b100;
              err       <= 1'b0;
            end
            default: begin
              done_data <= '0;
              err       <= 1'b1;
            end
          endcase
        end
        WB: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural 32-bit ALU attached to its operand outputs.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_ra, cmd_rb, cmd_rd;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero, alu_carry, alu_overflow;
  logic        done;
  logic [31:0] done_data;
  logic [2:0]  flags;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.WIDTH(32), .NREGS(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow),
    .done(done), .done_data(done_data), .flags(flags), .err(err)
  );

  // Combinational ALU stand-in: SUB reports borrow as carry; compares yield a 0/1 result.
  logic [32:0] sum;
  always_comb begin
    sum          = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'b0011: alu_result = alu_a | alu_b;
      4'b0101: alu_result = alu_a & alu_b;
      4'b0110: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum[31:0];
        alu_carry    = sum[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'b1000: begin
        alu_result   = alu_a - alu_b;
        alu_carry    = (alu_a < alu_b);
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'b1100: alu_result = {31'd0, alu_a == alu_b};
      4'b1101: alu_result = {31'd0, $signed(alu_a) > $signed(alu_b)};
      4'b1110: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    step();
    ld_en = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    rd_addr = addr;
    #1;
    chk(tag, rd_data, exp);
  endtask

  // Issues one command and checks EXEC operands, the WB completion and the return to IDLE.
  task automatic run_cmd(input string tag, input logic [3:0] op,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ed, input logic [2:0] ef, input logic ee);
    for (int i = 0; i < 20 && !cmd_ready; i++) step();
    if (!cmd_ready) chk({tag, "_rdy_timeout"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
    step();
    cmd_valid = 1'b0; ld_en = 1'b0;
    chk({tag, "_a"},      alu_a, ea);
    chk({tag, "_b"},      alu_b, eb);
    chk({tag, "_op"},     32'(alu_op), 32'(op));
    chk({tag, "_exrdy"},  32'(cmd_ready), 32'd0);
    chk({tag, "_exdone"}, 32'(done), 32'd0);
    step();
    chk({tag, "_done"},   32'(done), 32'd1);
    chk({tag, "_data"},   done_data, ed);
    chk({tag, "_flags"},  32'(flags), 32'(ef));
    chk({tag, "_err"},    32'(err), 32'(ee));
    chk({tag, "_opclr"},  32'(alu_op), 32'd0);
    chk({tag, "_ahold"},  alu_a, ea);
    step();
    chk({tag, "_done0"},  32'(done), 32'd0);
    chk({tag, "_rdy"},    32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int ndone;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    step(); step();
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_ddata", done_data, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_op",    32'(alu_op), 32'd0);
    chk("rst_a",     alu_a, 32'd0);
    peek("rst_rf0", 3'd0, 32'd0);
    reset = 1'b1;
    step();
    chk("rst_rdy", 32'(cmd_ready), 32'd1);

    // ADD with carry-out into a preloaded destination
    load(3'd1, 32'hFFFF_FFFF);
    load(3'd2, 32'h0000_0001);
    load(3'd3, 32'h0000_0055);
    run_cmd("add", 4'b0110, 3'd1, 3'd2, 3'd3, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b110, 1'b0);
    peek("add_r3", 3'd3, 32'h0);

    // Illegal opcodes: no write, flags keep 110
    run_cmd("e15", 4'b1111, 3'd1, 3'd2, 3'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b110, 1'b1);
    peek("e15_r1", 3'd1, 32'hFFFF_FFFF);
    run_cmd("e2", 4'b0010, 3'd1, 3'd2, 3'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b110, 1'b1);
    peek("e2_r2", 3'd2, 32'h1);

    // NOOP reports rf[rd] and clears err
    run_cmd("noop", 4'b0000, 3'd0, 3'd0, 3'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 3'b110, 1'b0);

    // SUB then signed LESS_THAN
    load(3'd1, 32'd5);
    load(3'd2, 32'd7);
    run_cmd("sub", 4'b1000, 3'd1, 3'd2, 3'd4, 32'd5, 32'd7, 32'hFFFF_FFFE, 3'b010, 1'b0);
    peek("sub_r4", 3'd4, 32'hFFFF_FFFE);
    run_cmd("lt", 4'b1110, 3'd1, 3'd2, 3'd5, 32'd5, 32'd7, 32'd1, 3'b000, 1'b0);
    peek("lt_r5", 3'd5, 32'd1);

    // Load and accept in the same cycle, same address: operand is pre-load, writeback wins
    load(3'd1, 32'd10);
    load(3'd2, 32'd20);
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'd99;
    run_cmd("ldcmd", 4'b0110, 3'd1, 3'd2, 3'd1, 32'd10, 32'd20, 32'd30, 3'b000, 1'b0);
    peek("ldcmd_r1", 3'd1, 32'd30);

    // Held cmd_valid, four ANDs, one every 3 cycles; load during EXEC is dropped
    load(3'd1, 32'hF0F0_FFFF);
    load(3'd2, 32'h0FF0_00FF);
    cmd_valid = 1'b1; cmd_op = 4'b0101; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_rd = 3'd6;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("held_op",  32'(alu_op), (c % 3 == 0) ? 32'd5 : 32'd0);
      chk("held_rdy", 32'(cmd_ready), (c % 3 == 2) ? 32'd1 : 32'd0);
      if (done) ndone++;
      if (c == 0) begin ld_en = 1'b1; ld_addr = 3'd7; ld_data = 32'hBAD; end
      if (c == 1) ld_en = 1'b0;
      if (c == 9) cmd_valid = 1'b0;
    end
    chk("held_ndone", 32'(ndone), 32'd4);
    peek("held_r6", 3'd6, 32'h00F0_00FF);
    peek("held_r7", 3'd7, 32'h0);

    // Reset during EXEC aborts the command
    load(3'd6, 32'h1234);
    cmd_valid = 1'b1; cmd_op = 4'b0110; cmd_ra = 3'd6; cmd_rb = 3'd6; cmd_rd = 3'd6;
    step();
    cmd_valid = 1'b0;
    chk("abort_exec", 32'(alu_op), 32'd6);
    reset = 1'b0;
    #1;
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) ndone++;
      step();
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (done) ndone++;
      step();
    end
    chk("abort_nodone", 32'(ndone), 32'd0);
    chk("abort_op",  32'(alu_op), 32'd0);
    chk("abort_rdy", 32'(cmd_ready), 32'd1);
    for (int r = 0; r < 8; r++) peek("abort_rf", 3'(r), 32'd0);

    // RESET opcode clears the destination without the ALU result
    load(3'd2, 32'hDEAD_BEEF);
    run_cmd("clr", 4'b0001, 3'd2, 3'd2, 3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 3'b100, 1'b0);
    peek("clr_r2", 3'd2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
